// File: rtl/pulse_train_pkg.sv
// pulse_train_pkg
//   Shared definitions for the pulse train generator: FSM state encoding and
//   the default counter width.
//   Optional feature macro used by the generator: PULSE_TRAIN_ABORT_EN.
package pulse_train_pkg;

  // Default width of tick/pulse counts and internal counters.
  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } pulse_state_t;

endpackage

// File: rtl/pulse_train_generator_phase_timer.sv
// phase_timer
//   Loadable down-counter that times one phase (high or low) of the train.
//   Loading V makes the phase last V+1 cycles; expired is high while the count
//   is zero and the counter holds at zero (no wrap).
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-high (count -> 0)
//   load       in   1      load load_value on this edge (wins over counting)
//   load_value in   CNT_W  value to load (phase length minus one)
//   value      out  CNT_W  current count
//   expired    out  1      count has reached zero
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] value,
  output logic             expired
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Phase count register: reset, load, or count down and stick at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= ZERO;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != ZERO) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign value   = count_r;
  assign expired = (count_r == ZERO);

endmodule

// File: rtl/pulse_train_generator.sv
// pulse_train_generator
//   Drives a registered line with a train of num_pulses pulses, each high for
//   high_ticks cycles and separated by low_ticks low cycles, on a start strobe.
//   Zero tick counts are treated as one; num_pulses==0 gives an empty train that
//   only strobes done. The final pulse skips its low phase, so done rises on the
//   cycle after the last high cycle.
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-high
//   start      in   1      one-cycle request, sampled only in IDLE
//   high_ticks in   CNT_W  cycles high per pulse
//   low_ticks  in   CNT_W  cycles low between pulses
//   num_pulses in   CNT_W  pulses in the train
//   pulse_out  out  1      generated line (registered)
//   busy       out  1      train in progress (registered)
//   done       out  1      one-cycle end-of-train strobe (registered)
//   abort      in   1      stop the train early (only with PULSE_TRAIN_ABORT_EN)
// Configuration macro: PULSE_TRAIN_ABORT_EN adds the abort port.
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_ticks,
  input  logic [CNT_W-1:0] low_ticks,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             pulse_out,
  output logic             busy,
`ifdef PULSE_TRAIN_ABORT_EN
  output logic             done,
  input  logic             abort
`else
  output logic             done
`endif
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  pulse_state_t     state_r;
  pulse_state_t     state_next_s;
  logic [CNT_W-1:0] pulses_r;
  logic [CNT_W-1:0] pulses_next_s;
  logic [CNT_W-1:0] high_m1_r;
  logic [CNT_W-1:0] low_m1_r;
  logic [CNT_W-1:0] high_m1_s;
  logic [CNT_W-1:0] low_m1_s;
  logic             latch_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             done_next_s;
  logic             abort_s;
  logic             pulse_out_r;
  logic             busy_r;
  logic             done_r;
  logic [CNT_W-1:0] timer_value_s;
  logic             timer_expired_s;

`ifdef PULSE_TRAIN_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Phase lengths minus one; a zero request behaves like one cycle.
  assign high_m1_s = (high_ticks == ZERO) ? ZERO : (high_ticks - ONE);
  assign low_m1_s  = (low_ticks  == ZERO) ? ZERO : (low_ticks  - ONE);

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_value (load_val_s),
    .value      (timer_value_s),
    .expired    (timer_expired_s)
  );

  // Next-state, phase-timer load and pulse-count decisions.
  always_comb begin
    state_next_s  = state_r;
    pulses_next_s = pulses_r;
    latch_s       = 1'b0;
    load_s        = 1'b0;
    load_val_s    = ZERO;
    done_next_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (num_pulses != ZERO) begin
            state_next_s  = S_HIGH;
            latch_s       = 1'b1;
            load_s        = 1'b1;
            load_val_s    = high_m1_s;
            pulses_next_s = num_pulses;
          end else begin
            // Empty train: acknowledge immediately without leaving IDLE.
            done_next_s = 1'b1;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_HIGH: begin
        if (abort_s) begin
          state_next_s  = S_IDLE;
          pulses_next_s = ZERO;
          done_next_s   = 1'b1;
        end else if (timer_expired_s) begin
          if (pulses_r == ONE) begin
            // Last pulse: no trailing low phase.
            state_next_s  = S_IDLE;
            pulses_next_s = ZERO;
            done_next_s   = 1'b1;
          end else begin
            state_next_s  = S_LOW;
            pulses_next_s = pulses_r - ONE;
            load_s        = 1'b1;
            load_val_s    = low_m1_r;
          end
        end else begin
          state_next_s = S_HIGH;
        end
      end
      S_LOW: begin
        if (abort_s) begin
          state_next_s  = S_IDLE;
          pulses_next_s = ZERO;
          done_next_s   = 1'b1;
        end else if (timer_expired_s) begin
          state_next_s = S_HIGH;
          load_s       = 1'b1;
          load_val_s   = high_m1_r;
        end else begin
          state_next_s = S_LOW;
        end
      end
      default: begin
        state_next_s  = S_IDLE;
        pulses_next_s = ZERO;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      pulses_r    <= ZERO;
      high_m1_r   <= ZERO;
      low_m1_r    <= ZERO;
      pulse_out_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pulses_r    <= pulses_next_s;
      if (latch_s) begin
        high_m1_r <= high_m1_s;
        low_m1_r  <= low_m1_s;
      end else begin
        high_m1_r <= high_m1_r;
        low_m1_r  <= low_m1_r;
      end
      pulse_out_r <= (state_next_s == S_HIGH);
      busy_r      <= (state_next_s == S_HIGH) || (state_next_s == S_LOW);
      done_r      <= done_next_s;
    end
  end

  assign pulse_out = pulse_out_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_pulse_train_generator.sv
module tb_pulse_train_generator;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] high_ticks;
  logic [CNT_W-1:0] low_ticks;
  logic [CNT_W-1:0] num_pulses;
  logic             pulse_out;
  logic             busy;
  logic             done;
`ifdef PULSE_TRAIN_ABORT_EN
  logic             abort;
`endif

  int n_checks;
  int n_fail;
  int rises;
  int falls;
  logic prev_pulse;

  pulse_train_generator #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .high_ticks (high_ticks),
    .low_ticks  (low_ticks),
    .num_pulses (num_pulses),
    .pulse_out  (pulse_out),
    .busy       (busy),
`ifdef PULSE_TRAIN_ABORT_EN
    .done       (done),
    .abort      (abort)
`else
    .done       (done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: strobes are cleared just after the sampling edge, outputs
  // are then observed on the falling edge and edges on the line counted.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort = 1'b0;
`endif
    @(negedge clk);
    if (pulse_out === 1'b1 && prev_pulse === 1'b0) rises++;
    if (pulse_out === 1'b0 && prev_pulse === 1'b1) falls++;
    prev_pulse = pulse_out;
  endtask

  task automatic step_check(input string tag, input logic ep, input logic eb, input logic ed);
    step();
    check({tag, "_pulse"}, pulse_out, ep);
    check({tag, "_busy"},  busy,      eb);
    check({tag, "_done"},  done,      ed);
  endtask

  task automatic set_cfg(input int h, input int l, input int n);
    high_ticks = CNT_W'(h);
    low_ticks  = CNT_W'(l);
    num_pulses = CNT_W'(n);
  endtask

  // Expected line value k cycles after the start cycle, from effective H/L/N.
  function automatic logic exp_pulse(input int h, input int l, input int n, input int k);
    int last;
    last = n * h + (n - 1) * l;
    if (n == 0 || k < 1 || k > last) return 1'b0;
    return (((k - 1) % (h + l)) < h) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic exp_busy(input int h, input int l, input int n, input int k);
    if (n == 0) return 1'b0;
    return (k >= 1 && k <= n * h + (n - 1) * l) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic exp_done(input int h, input int l, input int n, input int k);
    if (n == 0) return (k == 1) ? 1'b1 : 1'b0;
    return (k == n * h + (n - 1) * l + 1) ? 1'b1 : 1'b0;
  endfunction

  // Start a train and check every cycle through a little past done.
  task automatic run_train(input string tag, input int h, input int l, input int n,
                           input int he, input int le);
    int last;
    set_cfg(h, l, n);
    start = 1'b1;
    rises = 0;
    falls = 0;
    last = (n == 0) ? 3 : n * he + (n - 1) * le + 2;
    for (int k = 1; k <= last; k++) begin
      step_check($sformatf("%s_k%0d", tag, k), exp_pulse(he, le, n, k),
                 exp_busy(he, le, n, k), exp_done(he, le, n, k));
    end
    check_int({tag, "_rises"}, rises, n);
    check_int({tag, "_falls"}, falls, n);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rises      = 0;
    falls      = 0;
    prev_pulse = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
`ifdef PULSE_TRAIN_ABORT_EN
    abort      = 1'b0;
`endif
    set_cfg(0, 0, 0);

    // Reset state
    step();
    step_check("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step_check("idle", 1'b0, 1'b0, 1'b0);

    // H=2 L=3 N=3: highs at 1-2, 6-7, 11-12; done at 13
    run_train("h2l3n3", 2, 3, 3, 2, 3);
    // zero ticks behave as one: high 1, low 2, high 3, done 4
    run_train("h0l0n2", 0, 0, 2, 1, 1);
    // empty train: done at 1 only
    run_train("n0", 5, 5, 0, 5, 5);
    // single long pulse
    run_train("h4n1", 4, 7, 1, 4, 7);

    // Re-start while busy with new config is ignored; start in done cycle accepted
    set_cfg(1, 1, 2);
    start = 1'b1;
    step_check("ign_k1", 1'b1, 1'b1, 1'b0);
    set_cfg(5, 5, 9);
    start = 1'b1;
    step_check("ign_k2", 1'b0, 1'b1, 1'b0);
    step_check("ign_k3", 1'b1, 1'b1, 1'b0);
    step_check("ign_k4", 1'b0, 1'b0, 1'b1);
    set_cfg(1, 2, 1);
    start = 1'b1;
    step_check("b2b_k5", 1'b1, 1'b1, 1'b0);
    step_check("b2b_k6", 1'b0, 1'b0, 1'b1);
    step_check("b2b_k7", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a high phase: line low, no done
    set_cfg(4, 1, 2);
    start = 1'b1;
    step_check("rst_k1", 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step_check("rst_k2", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 3; k <= 8; k++) begin
      step_check($sformatf("rst_after_k%0d", k), 1'b0, 1'b0, 1'b0);
    end

    // Fresh train after reset still behaves normally
    run_train("post_rst", 1, 2, 2, 1, 2);

`ifdef PULSE_TRAIN_ABORT_EN
    // Abort during the second high phase
    set_cfg(2, 1, 3);
    start = 1'b1;
    step_check("abt_k1", 1'b1, 1'b1, 1'b0);
    step_check("abt_k2", 1'b1, 1'b1, 1'b0);
    step_check("abt_k3", 1'b0, 1'b1, 1'b0);
    step_check("abt_k4", 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    step_check("abt_k5", 1'b0, 1'b0, 1'b1);
    step_check("abt_k6", 1'b0, 1'b0, 1'b0);
    // Abort together with start in IDLE: start wins
    set_cfg(1, 1, 1);
    start = 1'b1;
    abort = 1'b1;
    step_check("abt_st_k1", 1'b1, 1'b1, 1'b0);
    step_check("abt_st_k2", 1'b0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
